// File: rtl/cr_tcipif_ahbl_master.sv
// cr_tcipif_ahbl_master: AHB-Lite slave that replays single transfers as tcipif
// requests to the CLIC, with alignment checking, completion timeout and registered read data.
module cr_tcipif_ahbl_master #(
   parameter int TIMEOUT = 16
) (
   input  logic        forever_cpuclk,
   input  logic        cpurst_b,
   input  logic        ahbl_hsel,
   input  logic [1:0]  ahbl_htrans,
   input  logic [31:0] ahbl_haddr,
   input  logic [2:0]  ahbl_hsize,
   input  logic        ahbl_hwrite,
   input  logic [31:0] ahbl_hwdata,
   input  logic        ahbl_hreadyin,
   output logic        ahbl_hreadyout,
   output logic        ahbl_hresp,
   output logic [31:0] ahbl_hrdata,
   output logic        tcipif_clic_sel,
   output logic [15:0] tcipif_clic_addr,
   output logic [1:0]  tcipif_clic_size,
   output logic        tcipif_clic_write,
   output logic [31:0] tcipif_clic_wdata,
   input  logic        clic_tcipif_cmplt,
   input  logic [31:0] clic_tcipif_rdata
);
   typedef enum logic [2:0] {IDLE, REQ, DONE, ERR1, ERR2} state_t;
   state_t      state, state_nxt;
   logic [15:0] addr_q;
   logic [2:0]  size_q;
   logic        write_q;
   logic [7:0]  cnt;
   logic [31:0] rdata_q;
   logic        capture, legal, unused;
   assign unused = ^{ahbl_haddr[31:16], ahbl_htrans[0]};
   assign ahbl_hreadyout = state == IDLE || state == DONE || state == ERR2;
   assign ahbl_hresp = state == ERR1 || state == ERR2;
   assign ahbl_hrdata = rdata_q;
   assign tcipif_clic_sel = state == REQ;
   assign tcipif_clic_addr = addr_q;
   assign tcipif_clic_size = size_q[1:0];
   assign tcipif_clic_write = write_q;
   assign tcipif_clic_wdata = ahbl_hwdata;
   assign capture = ahbl_hsel && ahbl_htrans[1] && ahbl_hreadyin && ahbl_hreadyout;
   // legality decided from the same bus values that get captured this cycle
   assign legal = ahbl_hsize == 3'd0 || (ahbl_hsize == 3'd1 && !ahbl_haddr[0]) ||
                  (ahbl_hsize == 3'd2 && ahbl_haddr[1:0] == 2'd0);
   always_comb begin
      state_nxt = state;
      state_nxt = state == REQ  ? (clic_tcipif_cmplt ? DONE : cnt == 8'(TIMEOUT - 1) ? ERR1 : REQ) :
                  state == ERR1 ? ERR2 :
                  capture       ? (legal ? REQ : ERR1) : IDLE;
   end
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state   <= IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         cnt     <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            addr_q  <= ahbl_haddr[15:0];
            size_q  <= ahbl_hsize;
            write_q <= ahbl_hwrite;
         end
         cnt <= (capture && legal) ? 8'd0 : state == REQ ? cnt + 8'd1 : cnt;
         if (state == REQ && clic_tcipif_cmplt)
            rdata_q <= write_q ? 32'd0 : clic_tcipif_rdata;
         else if (state_nxt == ERR1)
            rdata_q <= 32'd0;
      end
   end
endmodule

// File: tb/tb_cr_tcipif_ahbl_master.sv
// tb_cr_tcipif_ahbl_master: directed bench for the AHB-Lite to tcipif bridge
// with a small configurable-latency CLIC responder.
module tb_cr_tcipif_ahbl_master;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hsel = 1'b0;
   logic [1:0]  htrans = 2'b00;
   logic [31:0] haddr = '0;
   logic [2:0]  hsize = '0;
   logic        hwrite = 1'b0;
   logic [31:0] hwdata = '0;
   logic        hreadyin = 1'b1;
   logic        hreadyout, hresp;
   logic [31:0] hrdata;
   logic        sel, write;
   logic [15:0] addr;
   logic [1:0]  size;
   logic [31:0] wdata;
   logic        cmplt;
   logic [31:0] rdata = '0;
   logic        resp_en = 1'b1;
   logic [7:0]  resp_k = '0;
   logic [7:0]  sel_cnt;
   int          checks = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   cr_tcipif_ahbl_master #(.TIMEOUT(16)) dut (
      .forever_cpuclk(clk), .cpurst_b(rst_n),
      .ahbl_hsel(hsel), .ahbl_htrans(htrans), .ahbl_haddr(haddr), .ahbl_hsize(hsize),
      .ahbl_hwrite(hwrite), .ahbl_hwdata(hwdata), .ahbl_hreadyin(hreadyin),
      .ahbl_hreadyout(hreadyout), .ahbl_hresp(hresp), .ahbl_hrdata(hrdata),
      .tcipif_clic_sel(sel), .tcipif_clic_addr(addr), .tcipif_clic_size(size),
      .tcipif_clic_write(write), .tcipif_clic_wdata(wdata),
      .clic_tcipif_cmplt(cmplt), .clic_tcipif_rdata(rdata)
   );

   // responder completes resp_k cycles after sel rises (0 = combinational)
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sel_cnt <= '0;
      else sel_cnt <= sel ? sel_cnt + 8'd1 : 8'd0;
   assign cmplt = sel && resp_en && sel_cnt == resp_k;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // address phase driven now (at a negedge), then the data phase is observed to completion
   task automatic run(input string tag, input logic [31:0] a, input logic [2:0] s, input logic w,
                      input logic [31:0] wd, input int exp_sel, input int exp_cyc,
                      input logic exp_err, input logic [31:0] exp_rd);
      int   cyc = 0;
      int   nsel = 0;
      logic err = 1'b0;
      logic rdy = 1'b0;
      hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = s; hwrite = w; hreadyin = 1'b1;
      @(posedge clk);
      #1 htrans = 2'b00; hwdata = wd;
      while (!rdy && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (sel) begin
            nsel++;
            chk({tag, "_addr"}, 32'(addr), a & 32'h0000_ffff);
            chk({tag, "_size"}, 32'(size), 32'(s[1:0]));
            chk({tag, "_write"}, 32'(write), 32'(w));
            chk({tag, "_wdata"}, wdata, wd);
         end
         if (!hreadyout && hresp) err = 1'b1;
         rdy = hreadyout;
      end
      chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_sel_cycles"}, 32'(nsel), 32'(exp_sel));
      chk({tag, "_err1"}, 32'(err), 32'(exp_err));
      chk({tag, "_hresp"}, 32'(hresp), 32'(exp_err));
      chk({tag, "_hrdata"}, hrdata, exp_rd);
   endtask

   initial begin
      #2;
      chk("rst_hready", 32'(hreadyout), 32'd1);
      chk("rst_hresp", 32'(hresp), 32'd0);
      chk("rst_hrdata", hrdata, 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_size", 32'(size), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      rdata = 32'hA5A5_0081;
      run("rd_word", 32'h0000_1004, 3'd2, 1'b0, 32'h0, 1, 2, 1'b0, 32'hA5A5_0081);
      @(negedge clk);
      chk("rd_hold", hrdata, 32'hA5A5_0081);
      chk("idle_hready", 32'(hreadyout), 32'd1);
      chk("idle_hresp", 32'(hresp), 32'd0);
      run("wr_byte", 32'h0000_100F, 3'd0, 1'b1, 32'h0300_0000, 1, 2, 1'b0, 32'h0);
      @(negedge clk);
      run("b2b_wr", 32'h0000_0008, 3'd2, 1'b1, 32'hDEAD_BEEF, 1, 2, 1'b0, 32'h0);
      rdata = 32'h1234_5678;
      run("b2b_rd", 32'h0000_0000, 3'd2, 1'b0, 32'h0, 1, 2, 1'b0, 32'h1234_5678);
      resp_k = 8'd3; rdata = 32'h0000_BEEF;
      run("rd_half_k3", 32'h0000_2002, 3'd1, 1'b0, 32'h0, 4, 5, 1'b0, 32'h0000_BEEF);
      run("half_odd", 32'h0000_1001, 3'd1, 1'b0, 32'h0, 0, 2, 1'b1, 32'h0);
      run("size3", 32'h0000_1000, 3'd3, 1'b0, 32'h0, 0, 2, 1'b1, 32'h0);
      @(negedge clk);
      chk("err_cancel_hready", 32'(hreadyout), 32'd1);
      chk("err_cancel_hresp", 32'(hresp), 32'd0);
      resp_k = 8'd0; rdata = 32'h7777_0001;
      run("rd_pre_tmo", 32'h0000_1018, 3'd2, 1'b0, 32'h0, 1, 2, 1'b0, 32'h7777_0001);
      resp_en = 1'b0;
      run("timeout", 32'h0000_1008, 3'd2, 1'b0, 32'h0, 16, 18, 1'b1, 32'h0);
      resp_en = 1'b1; resp_k = 8'd15; rdata = 32'hCAFE_0001;
      run("tmo_edge", 32'h0000_100C, 3'd2, 1'b0, 32'h0, 16, 17, 1'b0, 32'hCAFE_0001);
      @(negedge clk);
      resp_en = 1'b0;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_1010; hsize = 3'd2; hwrite = 1'b0;
      @(posedge clk);
      #1 htrans = 2'b00;
      @(posedge clk);
      @(posedge clk);
      #2 chk("pre_rst_sel", 32'(sel), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_sel", 32'(sel), 32'd0);
      chk("arst_hready", 32'(hreadyout), 32'd1);
      chk("arst_hresp", 32'(hresp), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; hsel = 1'b0;
      @(negedge clk);
      resp_en = 1'b1; resp_k = 8'd0; rdata = 32'h0F0F_0F0F;
      run("post_rst", 32'h0000_1010, 3'd2, 1'b0, 32'h0, 1, 2, 1'b0, 32'h0F0F_0F0F);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
